dcache_arbiter: RTL and testbench
=================================

# dcache_arbiter

Round-robin arbiter that shares one core's single data-cache read port among that core's per-thread LSUs. It serialises LSU read requests onto the cache's pulse-request / pulse-valid interface and returns each result to the requesting LSU as a one-cycle ready strobe. It sits between the LSUs and the data cache, one instance per core. It is read-only, like the cache it fronts.

## Interface
Parameters:
- NUM_REQUESTERS, 4: number of LSU ports (threads per block); power of 2, ≥2.
- ADDR_BITS, 8: data memory address width.
- DATA_BITS, 8: data memory word width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high.
- lsu_read_valid  in  NUM_REQUESTERS  per-LSU request level; each LSU holds it until it sees its ready bit.
- lsu_read_address  in  NUM_REQUESTERS*ADDR_BITS  packed; slice i belongs to LSU i.
- lsu_read_ready  out  NUM_REQUESTERS  one-cycle completion strobe, one-hot or zero.
- lsu_read_data  out  NUM_REQUESTERS*DATA_BITS  packed; slice i is valid while ready[i]=1.
- cache_read_request  out  1  one-cycle request pulse to the cache.
- cache_read_address  out  ADDR_BITS  held stable from the request pulse until cache_read_valid.
- cache_read_valid  in  1  one-cycle completion pulse from the cache.
- cache_read_data  in  DATA_BITS  valid when cache_read_valid=1.

## Operation
- All outputs are registered. FSM states: IDLE, REQ, WAIT, DONE.
- IDLE:
  - If any lsu_read_valid is set, grant the first set bit at or after rr_ptr, scanning upward with wrap to 0.
  - Latch grant index g; cache_read_address <= address slice g; cache_read_request <= 1; go to REQ.
- REQ: cache_read_request <= 0; go to WAIT. The request is exactly one cycle high, so the cache never sees a duplicate.
- WAIT:
  - Hold cache_read_address.
  - On cache_read_valid: lsu_read_data slice g <= cache_read_data; lsu_read_ready[g] <= 1; rr_ptr <= g+1 (mod NUM_REQUESTERS); go to DONE.
  - No timeout: WAIT persists until cache_read_valid arrives.
- DONE:
  - lsu_read_ready <= 0; go to IDLE.
  - This cycle is a cooldown. The granted LSU drops its valid on the same edge, so it is not re-granted spuriously.
- Data output slices keep their last value; only slice g is written.
- lsu_read_valid bits that fall before being granted are simply not granted. A request withdrawn after grant still completes, with no ready pulse lost or redirected.
- cache_read_valid while not in WAIT is ignored.

## Timing
- Reset values: state IDLE, rr_ptr 0, cache_read_request 0, cache_read_address 0, lsu_read_ready 0, lsu_read_data all 0.
- Edge numbering: grant on edge k; request pulse high during cycle k..k+1; cache samples the request at edge k+1.
- On a cache hit:
  - cache_read_valid is visible after k+2 and sampled at k+3.
  - ready is high during k+3..k+4.
  - The LSU-valid-to-ready latency is 3 cycles.
- On a miss, latency is 3 plus the cache miss time.
- Minimum spacing between successive grants is 5 edges.
- Simultaneous requests: one grant per transaction, strict round robin. For N continuously requesting LSUs, each is served once per N transactions.
- Reset mid-transaction: abandon it at once and return every output to its reset value; the cache shares the same reset.

## Configuration
- DCACHE_ARB_STATS_EN defined:
  - Adds outputs stat_grants (16 bits) and stat_stall_cycles (16 bits), both reset to 0.
  - stat_grants increments on each IDLE→REQ transition.
  - stat_stall_cycles increments on every cycle in which some lsu_read_valid bit is set but that LSU is not the current grant, or the FSM is not in IDLE.
  - Both counters saturate at 0xFFFF.
- DCACHE_ARB_STATS_EN undefined: these ports and counters do not exist; behaviour is otherwise identical.

## Test plan
- Single request, hit:
  - Stimulus: LSU2 valid, address 0x15; cache model returns 0x5A on its first valid pulse.
  - Required: exactly one request pulse carrying address 0x15; ready[2] is high for one cycle with data slice 2 = 0x5A, 3 edges after the grant.
- Miss with long latency:
  - Stimulus: cache returns its valid 20 cycles after the request.
  - Required: cache_read_address stays stable the whole time and request is never re-pulsed; ready pulses once.
- All four LSUs valid at once, addresses 0x00/0x01/0x02/0x03:
  - Required: grants in order 0,1,2,3, each data slice correct, no request re-granted.
- Fairness:
  - Stimulus: LSU0 and LSU3 re-request continuously.
  - Required: grants alternate 0,3,0,3.
- Reset mid-WAIT:
  - Stimulus: reset asserted for 1 cycle while in WAIT.
  - Required: all outputs 0; a later request from LSU1 is granted first (rr_ptr=0) and completes normally.
- With DCACHE_ARB_STATS_EN:
  - Stimulus: the 4-LSU scenario above.
  - Required: stat_grants = 4, and stat_stall_cycles matches the scoreboard count.

Source files
------------

// File: rtl/dcache_arbiter_if.sv
// dcache_arbiter_if: LSU-side and cache-side read signals shared by the
// per-core data-cache arbiter. The master modport is the arbiter; the slave
// modport is the surrounding LSUs plus the data cache.
interface dcache_arbiter_if #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned DATA_BITS      = 8
);

  logic [NUM_REQUESTERS-1:0]           lsu_read_valid;
  logic [NUM_REQUESTERS*ADDR_BITS-1:0] lsu_read_address;
  logic [NUM_REQUESTERS-1:0]           lsu_read_ready;
  logic [NUM_REQUESTERS*DATA_BITS-1:0] lsu_read_data;
  logic                                cache_read_request;
  logic [ADDR_BITS-1:0]                cache_read_address;
  logic                                cache_read_valid;
  logic [DATA_BITS-1:0]                cache_read_data;

  modport master (
    input  lsu_read_valid,
    input  lsu_read_address,
    output lsu_read_ready,
    output lsu_read_data,
    output cache_read_request,
    output cache_read_address,
    input  cache_read_valid,
    input  cache_read_data
  );

  modport slave (
    output lsu_read_valid,
    output lsu_read_address,
    input  lsu_read_ready,
    input  lsu_read_data,
    input  cache_read_request,
    input  cache_read_address,
    output cache_read_valid,
    output cache_read_data
  );

endinterface

// File: rtl/dcache_arbiter.sv
// dcache_arbiter: round-robin arbiter sharing one core's data-cache read port
// among its per-thread LSUs. One transaction at a time: IDLE -> REQ -> WAIT ->
// DONE, with a one-cycle request pulse and a one-cycle ready strobe.
// Optional feature macro: DCACHE_ARB_STATS_EN adds saturating grant and
// stall-cycle counters on ports stat_grants_o / stat_stall_cycles_o.
module dcache_arbiter #(
  parameter int unsigned NUM_REQUESTERS = 4,
  parameter int unsigned ADDR_BITS      = 8,
  parameter int unsigned DATA_BITS      = 8
) (
  input  logic                    clk,
  input  logic                    reset,
`ifdef DCACHE_ARB_STATS_EN
  output logic [15:0]             stat_grants_o,
  output logic [15:0]             stat_stall_cycles_o,
`endif
  dcache_arbiter_if.master        bus
);

  localparam int unsigned IDX_BITS = $clog2(NUM_REQUESTERS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  state_e                              state_q, state_d;
  logic [IDX_BITS-1:0]                 rr_ptr_q, rr_ptr_d;
  logic [IDX_BITS-1:0]                 grant_q, grant_d;
  logic                                req_q, req_d;
  logic [ADDR_BITS-1:0]                addr_q, addr_d;
  logic [NUM_REQUESTERS-1:0]           ready_q, ready_d;
  logic [NUM_REQUESTERS*DATA_BITS-1:0] data_q, data_d;

  logic                                pick_vld;
  logic [IDX_BITS-1:0]                 pick_idx;
  logic [IDX_BITS-1:0]                 cand;

  // First requesting LSU at or after rr_ptr, wrapping (power-of-2 count).
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int unsigned off = 0; off < NUM_REQUESTERS; off++) begin
      cand = rr_ptr_q + IDX_BITS'(off);
      if (!pick_vld && bus.lsu_read_valid[cand]) begin
        pick_vld = 1'b1;
        pick_idx = cand;
      end
    end
  end

  // Next-state and registered-output logic for the transaction FSM.
  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    grant_d  = grant_q;
    req_d    = 1'b0;
    addr_d   = addr_q;
    ready_d  = '0;
    data_d   = data_q;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_idx;
          addr_d  = bus.lsu_read_address[pick_idx*ADDR_BITS +: ADDR_BITS];
          req_d   = 1'b1;
          state_d = REQ;
        end
      end
      REQ: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.cache_read_valid) begin
          data_d[grant_q*DATA_BITS +: DATA_BITS] = bus.cache_read_data;
          ready_d[grant_q] = 1'b1;
          rr_ptr_d         = grant_q + IDX_BITS'(1);
          state_d          = DONE;
        end
      end
      DONE: begin
        // Cooldown: the served LSU drops its valid on this edge.
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      rr_ptr_q <= '0;
      grant_q  <= '0;
      req_q    <= 1'b0;
      addr_q   <= '0;
      ready_q  <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      grant_q  <= grant_d;
      req_q    <= req_d;
      addr_q   <= addr_d;
      ready_q  <= ready_d;
      data_q   <= data_d;
    end
  end

  assign bus.cache_read_request = req_q;
  assign bus.cache_read_address = addr_q;
  assign bus.lsu_read_ready     = ready_q;
  assign bus.lsu_read_data      = data_q;

`ifdef DCACHE_ARB_STATS_EN
  logic [15:0]               stat_grants_q, stat_grants_d;
  logic [15:0]               stat_stall_q, stat_stall_d;
  logic [NUM_REQUESTERS-1:0] pick_oh;
  logic                      stall;

  // A cycle stalls when any LSU waits: FSM busy, or another LSU loses the pick.
  always_comb begin
    pick_oh = '0;
    if (pick_vld) begin
      pick_oh[pick_idx] = 1'b1;
    end
    stall = (|bus.lsu_read_valid) &&
            ((state_q != IDLE) || (|(bus.lsu_read_valid & ~pick_oh)));
    stat_grants_d = stat_grants_q;
    stat_stall_d  = stat_stall_q;
    if ((state_q == IDLE) && pick_vld && (stat_grants_q != 16'hFFFF)) begin
      stat_grants_d = stat_grants_q + 16'd1;
    end
    if (stall && (stat_stall_q != 16'hFFFF)) begin
      stat_stall_d = stat_stall_q + 16'd1;
    end
  end

  // Saturating statistics counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_grants_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_grants_q <= stat_grants_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_grants_o       = stat_grants_q;
  assign stat_stall_cycles_o = stat_stall_q;
`endif

endmodule

// File: tb/tb_dcache_arbiter.sv
// tb_dcache_arbiter: directed bench with an LSU/cache model and a scoreboard of
// expected cache requests and LSU completions.
module tb_dcache_arbiter;

  localparam int unsigned NR = 4;
  localparam int unsigned AB = 8;
  localparam int unsigned DB = 8;

  typedef struct {
    logic [AB-1:0] addr;
    int            lat;
  } req_exp_t;

  typedef struct {
    int            lsu;
    logic [DB-1:0] data;
  } rd_exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  dcache_arbiter_if #(.NUM_REQUESTERS(NR), .ADDR_BITS(AB), .DATA_BITS(DB)) bus ();

`ifdef DCACHE_ARB_STATS_EN
  logic [15:0] stat_grants;
  logic [15:0] stat_stall;
`endif

  dcache_arbiter #(.NUM_REQUESTERS(NR), .ADDR_BITS(AB), .DATA_BITS(DB)) dut (
    .clk                 (clk),
    .reset               (reset),
`ifdef DCACHE_ARB_STATS_EN
    .stat_grants_o       (stat_grants),
    .stat_stall_cycles_o (stat_stall),
`endif
    .bus                 (bus)
  );

  always #5 clk = ~clk;

  int            passed = 0;
  int            total  = 0;
  req_exp_t      req_q[$];
  rd_exp_t       rd_q[$];
  int            cyc          = 0;
  int            req_cyc      = 0;
  int            lat_cur      = 0;
  int            cnt          = 0;
  int            grants_model = 0;
  int            stall_model  = 0;
  int            reraise_left[NR];
  logic          pending   = 1'b0;
  logic          busy      = 1'b0;
  logic          done_flag = 1'b0;
  logic          req_prev  = 1'b0;
  logic [AB-1:0] cache_addr = '0;
  logic [NR-1:0] rearm = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [DB-1:0] cache_word(input logic [AB-1:0] a);
    return a ^ 8'h4F;
  endfunction

  // Stall reference: some LSU waits while busy, or several compete in IDLE.
  always @(posedge clk) begin
    if (reset) stall_model <= 0;
    else if ((|bus.lsu_read_valid) && (busy || ($countones(bus.lsu_read_valid) > 1)))
      stall_model <= stall_model + 1;
  end

  // One cycle of LSU + cache model and scoreboard, evaluated at the negedge.
  task automatic tick();
    req_exp_t e;
    rd_exp_t  r;
    @(negedge clk);
    cyc++;
    if (reset) return;
    if (done_flag) begin
      busy      = 1'b0;
      done_flag = 1'b0;
    end
    bus.lsu_read_valid = bus.lsu_read_valid | rearm;
    rearm = '0;
    if (bus.cache_read_valid) begin
      bus.cache_read_valid = 1'b0;
      bus.cache_read_data  = 8'hEE;
    end
    if (pending) begin
      if (cnt == 0) begin
        bus.cache_read_valid = 1'b1;
        bus.cache_read_data  = cache_word(cache_addr);
        pending = 1'b0;
      end else begin
        cnt--;
      end
    end
    if (bus.cache_read_request) begin
      check("req_single_pulse", 32'(req_prev), 32'd0);
      check("req_expected", 32'(req_q.size() > 0), 32'd1);
      grants_model++;
      if (req_q.size() > 0) begin
        e = req_q.pop_front();
        check("req_addr", 32'(bus.cache_read_address), 32'(e.addr));
        pending    = 1'b1;
        cnt        = 1 + e.lat;
        lat_cur    = e.lat;
        req_cyc    = cyc;
        cache_addr = bus.cache_read_address;
        busy       = 1'b1;
      end
    end else if (pending || bus.cache_read_valid) begin
      check("addr_stable", 32'(bus.cache_read_address), 32'(cache_addr));
    end
    req_prev = bus.cache_read_request;
    if (bus.lsu_read_ready != '0) begin
      check("ready_expected", 32'(rd_q.size() > 0), 32'd1);
      if (rd_q.size() > 0) begin
        r = rd_q.pop_front();
        check("ready_onehot", 32'(bus.lsu_read_ready), 32'(1) << r.lsu);
        check("ready_data", 32'(bus.lsu_read_data[r.lsu*DB +: DB]), 32'(r.data));
        check("ready_latency", 32'(cyc - req_cyc), 32'(3 + lat_cur));
        bus.lsu_read_valid[r.lsu] = 1'b0;
        if (reraise_left[r.lsu] > 0) begin
          rearm[r.lsu] = 1'b1;
          reraise_left[r.lsu]--;
        end
      end
      done_flag = 1'b1;
    end
  endtask

  task automatic raise(input int lsu, input logic [AB-1:0] addr);
    bus.lsu_read_address[lsu*AB +: AB] = addr;
    bus.lsu_read_valid[lsu] = 1'b1;
  endtask

  task automatic expect_txn(input int lsu, input logic [AB-1:0] addr, input int lat);
    req_exp_t e;
    rd_exp_t  r;
    e.addr = addr;
    e.lat  = lat;
    req_q.push_back(e);
    r.lsu  = lsu;
    r.data = cache_word(addr);
    rd_q.push_back(r);
  endtask

  task automatic wait_done(input int limit);
    int n = 0;
    while (((rd_q.size() != 0) || busy) && (n < limit)) begin
      tick();
      n++;
    end
    check("wait_done_in_time", 32'(n < limit), 32'd1);
  endtask

  // One-cycle reset; the cache model and LSUs are reset alongside the DUT.
  task automatic do_reset();
    reset = 1'b1;
    bus.lsu_read_valid = '0;
    @(posedge clk);
    #1;
    pending      = 1'b0;
    busy         = 1'b0;
    done_flag    = 1'b0;
    req_prev     = 1'b0;
    rearm        = '0;
    grants_model = 0;
    bus.cache_read_valid = 1'b0;
    bus.cache_read_data  = 8'hEE;
    req_q.delete();
    rd_q.delete();
    foreach (reraise_left[i]) reraise_left[i] = 0;
    check("rst_ready", 32'(bus.lsu_read_ready), 32'd0);
    check("rst_request", 32'(bus.cache_read_request), 32'd0);
    check("rst_address", 32'(bus.cache_read_address), 32'd0);
    check("rst_data", 32'(bus.lsu_read_data), 32'd0);
`ifdef DCACHE_ARB_STATS_EN
    check("rst_stat_grants", 32'(stat_grants), 32'd0);
    check("rst_stat_stall", 32'(stat_stall), 32'd0);
`endif
    tick();
    reset = 1'b0;
  endtask

  initial begin
    logic [NR*DB-1:0] exp_data;
    bus.lsu_read_valid   = '0;
    bus.lsu_read_address = '0;
    bus.cache_read_valid = 1'b0;
    bus.cache_read_data  = 8'hEE;
    foreach (reraise_left[i]) reraise_left[i] = 0;
    do_reset();
    tick();

    // All four LSUs at once: strict order 0,1,2,3.
    for (int i = 0; i < 4; i++) expect_txn(i, AB'(i), 0);
    for (int i = 0; i < 4; i++) raise(i, AB'(i));
    wait_done(100);
`ifdef DCACHE_ARB_STATS_EN
    check("stat_grants_four", 32'(stat_grants), 32'd4);
    check("stat_stall_four", 32'(stat_stall), 32'(stall_model));
`endif
    tick();

    // Single hit on LSU2.
    expect_txn(2, 8'h15, 0);
    raise(2, 8'h15);
    wait_done(50);
    check("hit_slice2", 32'(bus.lsu_read_data[2*DB +: DB]), 32'h5A);

    // Long miss on LSU3.
    expect_txn(3, 8'h77, 20);
    raise(3, 8'h77);
    wait_done(100);

    // Stray cache valid while idle is ignored.
    tick();
    bus.cache_read_valid = 1'b1;
    bus.cache_read_data  = 8'h99;
    repeat (4) tick();
    check("stray_no_ready", 32'(bus.lsu_read_ready), 32'd0);
    exp_data = {cache_word(8'h77), cache_word(8'h15), cache_word(8'h01), cache_word(8'h00)};
    check("stray_data_kept", 32'(bus.lsu_read_data), 32'(exp_data));

    // Fairness: LSU0 and LSU3 re-request, grants alternate 0,3,0,3.
    reraise_left[0] = 1;
    reraise_left[3] = 1;
    expect_txn(0, 8'h30, 0);
    expect_txn(3, 8'h33, 1);
    expect_txn(0, 8'h30, 0);
    expect_txn(3, 8'h33, 1);
    raise(0, 8'h30);
    raise(3, 8'h33);
    wait_done(200);

    // Reset in WAIT, then LSU1 wins over LSU3 from rr_ptr 0.
    expect_txn(2, 8'h22, 0);
    raise(2, 8'h22);
    wait_done(50);
    expect_txn(2, 8'h40, 30);
    raise(2, 8'h40);
    repeat (6) tick();
    check("wait_addr_held", 32'(bus.cache_read_address), 32'h40);
    do_reset();
    expect_txn(1, 8'h11, 0);
    expect_txn(3, 8'h13, 0);
    raise(1, 8'h11);
    raise(3, 8'h13);
    wait_done(100);
    repeat (2) tick();
    check("final_no_ready", 32'(bus.lsu_read_ready), 32'd0);
`ifdef DCACHE_ARB_STATS_EN
    check("final_stat_grants", 32'(stat_grants), 32'(grants_model));
    check("final_stat_stall", 32'(stat_stall), 32'(stall_model));
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
